// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared types, constants and helpers for the Harris scan controller
package harris_pkg;

   localparam int WIN         = 6;
   localparam int CENTRE_OFF  = WIN / 2 - 1;
   localparam int COORD_MAX_W = 16;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   // Coordinates are carried at a fixed maximum width so the struct is frame-size agnostic.
   typedef struct packed {
      logic [COORD_MAX_W-1:0] x;
      logic [COORD_MAX_W-1:0] y;
      logic                   valid;
   } tag_t;

   function automatic int coord_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/harris_tag_pipe.sv
// rtl/harris_tag_pipe.sv - latency-matched shift register of window centre tags
module harris_tag_pipe
   import harris_pkg::*;
#(
   parameter int PIPE_LAT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  tag_t in_tag,
   output tag_t out_tag
);

   tag_t stages [PIPE_LAT];

   // Flush drops the incoming tag as well, so a window issued on the restart edge never emerges.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < PIPE_LAT; i++) stages[i] <= '0;
      end else begin
         stages[0] <= in_tag;
         for (int i = 1; i < PIPE_LAT; i++) stages[i] <= stages[i-1];
      end
   end

   assign out_tag = stages[PIPE_LAT-1];

endmodule

// File: rtl/harris_scan_ctrl.sv
// rtl/harris_scan_ctrl.sv - frame sequencer: raster tracking, window strobes, corner thresholding
module harris_scan_ctrl
   import harris_pkg::*;
#(
   parameter int                 IMG_W    = 64,
   parameter int                 IMG_H    = 64,
   parameter int                 PIPE_LAT = 4,
   parameter logic signed [63:0] R_THRESH = 64'sd65536,
   localparam int                CW       = coord_w(IMG_W),
   localparam int                RW       = coord_w(IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          frame_start,
   input  logic          pix_valid,
   output logic          pix_ready,
   output logic          lb_wr_en,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          win_valid,
   input  logic [63:0]   r_in,
   output logic          corner_valid,
   output logic [CW-1:0] corner_x,
   output logic [RW-1:0] corner_y,
   output logic [63:0]   count,
   output logic          frame_done
);

   localparam int            DCW       = $clog2(PIPE_LAT + 3);
   localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_H - 1);
   localparam logic [DCW-1:0] DRAIN_END = DCW'(PIPE_LAT + 1);

   state_t         state;
   logic [DCW-1:0] drain_cnt;
   logic [CW-1:0]  win_cx;
   logic [RW-1:0]  win_cy;
   logic           accept;
   logic           in_win;
   logic           last_pix;
   logic           is_corner;
   tag_t           pipe_in;
   tag_t           pipe_out;
   logic           unused_tag_hi;

   assign accept    = pix_valid & pix_ready;
   assign lb_wr_en  = accept;
   assign in_win    = (row >= RW'(WIN - 1)) && (col >= CW'(WIN - 1));
   assign last_pix  = (row == LAST_ROW) && (col == LAST_COL);
   assign is_corner = pipe_out.valid && ($signed(r_in) > R_THRESH);

   assign pipe_in       = {COORD_MAX_W'(win_cx), COORD_MAX_W'(win_cy), win_valid};
   assign unused_tag_hi = ^{pipe_out.x, pipe_out.y};

   harris_tag_pipe #(
      .PIPE_LAT (PIPE_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .flush   (frame_start),
      .in_tag  (pipe_in),
      .out_tag (pipe_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         drain_cnt    <= '0;
         pix_ready    <= 1'b0;
         col          <= '0;
         row          <= '0;
         win_valid    <= 1'b0;
         win_cx       <= '0;
         win_cy       <= '0;
         count        <= '0;
         corner_valid <= 1'b0;
         corner_x     <= '0;
         corner_y     <= '0;
         frame_done   <= 1'b0;
      end else if (frame_start) begin
         // Restart from any state; a coincident accept belongs to the abandoned frame.
         state        <= SCAN;
         drain_cnt    <= '0;
         pix_ready    <= 1'b1;
         col          <= '0;
         row          <= '0;
         win_valid    <= 1'b0;
         count        <= '0;
         corner_valid <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         win_valid    <= 1'b0;
         corner_valid <= 1'b0;
         frame_done   <= 1'b0;

         if (accept) begin
            if (col == LAST_COL) begin
               col <= '0;
               row <= (row == LAST_ROW) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
            if (in_win) begin
               win_valid <= 1'b1;
               win_cx    <= col - CW'(CENTRE_OFF);
               win_cy    <= row - RW'(CENTRE_OFF);
               count     <= count + 64'd1;
            end
         end

         if (is_corner) begin
            corner_valid <= 1'b1;
            corner_x     <= pipe_out.x[CW-1:0];
            corner_y     <= pipe_out.y[RW-1:0];
         end

         case (state)
            SCAN: begin
               if (accept && last_pix) begin
                  state     <= DRAIN;
                  pix_ready <= 1'b0;
                  drain_cnt <= '0;
               end
            end
            // Hold until the last window's tag has emerged and its corner has been registered.
            DRAIN: begin
               if (drain_cnt == DRAIN_END) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_harris_scan_ctrl.sv
// tb/tb_harris_scan_ctrl.sv - directed self-checking bench for harris_scan_ctrl on an 8x8 frame
module tb_harris_scan_ctrl;

   localparam int IMG_W    = 8;
   localparam int IMG_H    = 8;
   localparam int PIPE_LAT = 4;
   localparam int HIST     = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic        pix_valid;
   logic        pix_ready;
   logic        lb_wr_en;
   logic [2:0]  col;
   logic [2:0]  row;
   logic        win_valid;
   logic [63:0] r_in;
   logic        corner_valid;
   logic [2:0]  corner_x;
   logic [2:0]  corner_y;
   logic [63:0] count;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   harris_scan_ctrl #(
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_start  (frame_start),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .lb_wr_en     (lb_wr_en),
      .col          (col),
      .row          (row),
      .win_valid    (win_valid),
      .r_in         (r_in),
      .corner_valid (corner_valid),
      .corner_x     (corner_x),
      .corner_y     (corner_y),
      .count        (count),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   // Bench-side raster model and event log, sampled mid-cycle.
   int cyc = 0;
   bit mon_en = 1'b0;
   bit acc_ok [HIST];
   int hist_r [HIST];
   int hist_c [HIST];
   int m_row = 0, m_col = 0, frame_acc = 0;
   int coord_err = 0, wr_err = 0, win_err = 0, corner_err = 0;
   int n_win, n_corner, n_done, first_win_cyc, done_cyc, fs_cyc;
   int last_acc_cyc, acc55_cyc, acc57_cyc, corner_cyc;
   int r_mode = 0;

   always @(negedge clk) begin : monitor
      int t;
      bit exp_win;
      cyc = cyc + 1;
      if (cyc < HIST && mon_en) begin
         acc_ok[cyc] = 1'b0;
         if (lb_wr_en !== (pix_valid & pix_ready)) wr_err++;
         if (reset || frame_start) begin
            m_row = 0; m_col = 0; frame_acc = 0;
            if (frame_start) fs_cyc = cyc;
         end else if (pix_valid && pix_ready) begin
            acc_ok[cyc] = 1'b1;
            hist_r[cyc] = m_row;
            hist_c[cyc] = m_col;
            if (int'(row) !== m_row || int'(col) !== m_col) coord_err++;
            if (m_row == 5 && m_col == 5) acc55_cyc = cyc;
            if (m_row == 5 && m_col == 7) acc57_cyc = cyc;
            last_acc_cyc = cyc;
            frame_acc++;
            if (m_col == IMG_W - 1) begin
               m_col = 0;
               m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
         end
         exp_win = acc_ok[cyc-1] && hist_r[cyc-1] >= 5 && hist_c[cyc-1] >= 5;
         if (win_valid !== exp_win) win_err++;
         if (win_valid === 1'b1) begin
            if (first_win_cyc < 0) first_win_cyc = cyc;
            n_win++;
         end
         if (corner_valid === 1'b1) begin
            n_corner++;
            corner_cyc = cyc;
            t = cyc - (PIPE_LAT + 2);
            if (t < 1 || !acc_ok[t] || hist_r[t] < 5 || hist_c[t] < 5 ||
                int'(corner_x) !== hist_c[t] - 2 || int'(corner_y) !== hist_r[t] - 2)
               corner_err++;
         end
         if (frame_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   // Score source: r_in for cycle c answers the window accepted at c-(PIPE_LAT+1).
   initial begin : r_driver
      int t;
      r_in = 64'd0;
      forever begin
         @(posedge clk); #1;
         t = cyc + 1 - (PIPE_LAT + 1);
         case (r_mode)
            0: r_in = 64'd65536;
            1: r_in = (t >= 1 && t < HIST && acc_ok[t] && hist_r[t] == 5 && hist_c[t] == 7)
                      ? 64'd65537 : 64'd65536;
            2: r_in = -(64'sd1 <<< 40);
            default: r_in = 64'd1 << 20;
         endcase
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout cyc=%0d want=finish", cyc);
      $fatal(1, "bench timeout");
   end

   task automatic clear_stats();
      n_win = 0; n_corner = 0; n_done = 0;
      first_win_cyc = -1; done_cyc = -1; corner_cyc = -1;
      last_acc_cyc = -1; acc55_cyc = -1; acc57_cyc = -1;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      pix_valid   = 1'b0;
      clear_stats();
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   task automatic feed(input bit rnd, input int stop_at);
      int i = 0;
      while (frame_acc < stop_at && i < 2000) begin
         pix_valid = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
         @(posedge clk); #1;
         i++;
      end
      pix_valid = 1'b0;
      checks++;
      if (frame_acc != stop_at) begin
         failures++;
         $display("FAIL feed_accepts got=%0d want=%0d", frame_acc, stop_at);
      end
   endtask

   task automatic wait_done();
      int i = 0;
      while (n_done == 0 && i < 40) begin
         @(posedge clk); #1;
         i++;
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (n_done != 1) begin
         failures++;
         $display("FAIL frame_done_pulses got=%0d want=1", n_done);
      end
      checks++;
      if (done_cyc - last_acc_cyc != 7) begin
         failures++;
         $display("FAIL frame_done_delay got=%0d want=7", done_cyc - last_acc_cyc);
      end
      checks++;
      if (corner_cyc >= done_cyc) begin
         failures++;
         $display("FAIL corner_after_done corner_cyc=%0d done_cyc=%0d", corner_cyc, done_cyc);
      end
   endtask

   task automatic check_monitor(input string tag);
      checks++;
      if (coord_err + win_err + wr_err + corner_err != 0) begin
         failures++;
         $display("FAIL %s_monitor got coord=%0d win=%0d wr=%0d corner=%0d want all 0",
                  tag, coord_err, win_err, wr_err, corner_err);
      end
   endtask

   task automatic check_windows(input string tag, input int want_corners);
      checks++;
      if (n_win != 9) begin
         failures++;
         $display("FAIL %s_win_count got=%0d want=9", tag, n_win);
      end
      checks++;
      if (count !== 64'd9) begin
         failures++;
         $display("FAIL %s_count got=%0d want=9", tag, count);
      end
      checks++;
      if (n_corner != want_corners) begin
         failures++;
         $display("FAIL %s_corners got=%0d want=%0d", tag, n_corner, want_corners);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pix_valid = 1'b1; frame_start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({pix_ready, lb_wr_en, win_valid, corner_valid, frame_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                     {pix_ready, lb_wr_en, win_valid, corner_valid, frame_done});
         end
         checks++;
         if (count !== 64'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", count);
         end
         checks++;
         if ({row, col, corner_x, corner_y} !== 12'd0) begin
            failures++;
            $display("FAIL reset_coords got=%h want=000", {row, col, corner_x, corner_y});
         end
      end
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({pix_ready, lb_wr_en, win_valid} !== 3'b0) begin
            failures++;
            $display("FAIL idle_no_accept got=%b want=000", {pix_ready, lb_wr_en, win_valid});
         end
      end
      pix_valid = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_full_frame();
      r_mode = 3;
      start_frame();
      feed(1'b0, 64);
      wait_done();
      check_windows("full", 9);
      checks++;
      if (first_win_cyc - fs_cyc != 47) begin
         failures++;
         $display("FAIL full_first_win got=%0d want=47", first_win_cyc - fs_cyc);
      end
      checks++;
      if (first_win_cyc != acc55_cyc + 1) begin
         failures++;
         $display("FAIL full_first_win_vs_55 got=%0d want=%0d", first_win_cyc, acc55_cyc + 1);
      end
      checks++;
      if (last_acc_cyc - fs_cyc != 64) begin
         failures++;
         $display("FAIL full_last_accept got=%0d want=64", last_acc_cyc - fs_cyc);
      end
      check_monitor("full");
   endtask

   task automatic test_random_valid();
      r_mode = 3;
      start_frame();
      feed(1'b1, 64);
      wait_done();
      check_windows("random", 9);
      check_monitor("random");
   endtask

   task automatic test_threshold();
      r_mode = 0;
      start_frame();
      feed(1'b0, 64);
      wait_done();
      check_windows("thresh_eq", 0);
      checks++;
      if ({corner_x, corner_y} !== {3'd5, 3'd5}) begin
         failures++;
         $display("FAIL thresh_hold got=%0d,%0d want=5,5", corner_x, corner_y);
      end
      r_mode = 2;
      start_frame();
      feed(1'b0, 64);
      wait_done();
      check_windows("thresh_neg", 0);
      r_mode = 1;
      start_frame();
      feed(1'b0, 64);
      wait_done();
      check_windows("thresh_one", 1);
      checks++;
      if (corner_cyc - acc57_cyc != 6 || corner_cyc - fs_cyc != 54) begin
         failures++;
         $display("FAIL thresh_latency got=%0d,%0d want=6,54", corner_cyc - acc57_cyc, corner_cyc - fs_cyc);
      end
      checks++;
      if ({corner_x, corner_y} !== {3'd5, 3'd3}) begin
         failures++;
         $display("FAIL thresh_xy got=%0d,%0d want=5,3", corner_x, corner_y);
      end
      check_monitor("thresh");
   endtask

   task automatic test_restart();
      r_mode = 3;
      start_frame();
      feed(1'b0, 50);
      frame_start = 1'b1;
      pix_valid   = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      clear_stats();
      checks++;
      if (count !== 64'd0 || {row, col} !== 6'd0) begin
         failures++;
         $display("FAIL restart_clear got count=%0d row=%0d col=%0d want 0,0,0", count, row, col);
      end
      feed(1'b0, 64);
      wait_done();
      check_windows("restart", 9);
      check_monitor("restart");
   endtask

   task automatic test_reset_drain();
      r_mode = 3;
      start_frame();
      feed(1'b0, 64);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_corner = 0;
      n_done   = 0;
      checks++;
      if ({pix_ready, win_valid, corner_valid, frame_done} !== 4'b0 || count !== 64'd0) begin
         failures++;
         $display("FAIL drain_reset_state got flags=%b count=%0d want 0000,0",
                  {pix_ready, win_valid, corner_valid, frame_done}, count);
      end
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (n_done != 0 || n_corner != 0) begin
         failures++;
         $display("FAIL drain_reset_events got done=%0d corner=%0d want 0,0", n_done, n_corner);
      end
      checks++;
      if (count !== 64'd0 || pix_ready !== 1'b0) begin
         failures++;
         $display("FAIL drain_reset_idle got count=%0d ready=%b want 0,0", count, pix_ready);
      end
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_full_frame();
      test_random_valid();
      test_threshold();
      test_restart();
      test_reset_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
